// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback port arbiter.
// Optional starvation guard: WB_ARB_STARVE_GUARD_EN.
package wb_arb_pkg;

  typedef logic [4:0] rf_addr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_MDU
  } gnt_t;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_FIFO_DEPTH   = 2;
  localparam int DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/wb_result_fifo.sv
// MDU result buffer with per-entry valid bits and a
// parallel rd-match kill port.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  rf_addr_t              push_rd,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  rf_addr_t              kill_rd,
  output logic                  head_valid,
  output rf_addr_t              head_rd,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DEPTH-1:0]      vld;
  rf_addr_t              rds [DEPTH];
  logic [DATA_WIDTH-1:0] dat [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rds[i] <= '0;
        dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && vld[i] && rds[i] == kill_rd)
          vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      // push never targets the popped slot: full blocks push
      if (push) begin
        vld[wptr] <= 1'b1;
        rds[wptr] <= push_rd;
        dat[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  assign head_valid = vld[rptr];
  assign head_rd    = rds[rptr];
  assign head_data  = dat[rptr];
  assign count      = cnt;
  assign full       = (cnt == CW'(DEPTH));
  assign empty      = (cnt == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs MDU.
// Optional starvation guard: WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write_w,
  input  logic [4:0]            rd_w,
  input  logic [DATA_WIDTH-1:0] result_w,
  input  logic                  mdu_valid,
  input  logic [4:0]            mdu_rd,
  input  logic [DATA_WIDTH-1:0] mdu_result,
  output logic                  mdu_ready,
  output logic                  stall_w,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  gnt_t                  gnt;
  logic                  push;
  logic                  pop;
  logic                  pipe_eff;
  logic                  head_live;
  logic                  head_valid;
  rf_addr_t              head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;

  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready && (mdu_rd != '0);
  assign pipe_eff  = reg_write_w && (rd_w != '0);
  assign head_live = (count != '0) && head_valid;

  always_comb begin
    gnt = GNT_NONE;
    if (stall_w)
      gnt = GNT_MDU;
    else if (pipe_eff)
      gnt = GNT_PIPE;
    else if (head_live)
      gnt = GNT_MDU;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    unique case (gnt)
      GNT_PIPE: begin
        rf_we = 1'b1;
        rf_rd = rd_w;
        rf_wd = result_w;
      end
      GNT_MDU: begin
        rf_we = 1'b1;
        rf_rd = head_rd;
        rf_wd = head_data;
      end
      default: ;
    endcase
  end

  // killed heads are discarded silently alongside any grant
  assign pop = (gnt == GNT_MDU) || (!empty && !head_valid);

  wb_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_rd    (mdu_rd),
    .push_data  (mdu_result),
    .pop        (pop),
    .kill       (gnt == GNT_PIPE),
    .kill_rd    (rd_w),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve <= '0;
    else if (empty || gnt == GNT_MDU)
      starve <= '0;
    else if (starve != SW'(STARVE_LIMIT))
      starve <= starve + 1'b1;
  end

  assign stall_w = (starve == SW'(STARVE_LIMIT)) && head_live;
`else
  assign stall_w = 1'b0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and the out-of-order result stream of the long-latency multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into idle writeback slots. An optional starvation guard stalls the writeback stage for one cycle to force a drain. The block sits between the writeback stage / MDU and the register file.

## Interface
- `DATA_WIDTH`, 32, result width
- `FIFO_DEPTH`, 2, MDU result buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, cycles a non-empty FIFO head may wait before a forced drain
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `reg_write_w`  in  1  pipeline writeback request
- `rd_w`  in  5  pipeline destination register
- `result_w`  in  DATA_WIDTH  pipeline writeback data
- `mdu_valid`  in  1  MDU result valid
- `mdu_rd`  in  5  MDU destination register
- `mdu_result`  in  DATA_WIDTH  MDU result data
- `mdu_ready`  out  1  FIFO can accept an MDU result
- `stall_w`  out  1  writeback stage must hold its inputs this cycle
- `rf_we`  out  1  register-file write enable
- `rf_rd`  out  5  register-file write address
- `rf_wd`  out  DATA_WIDTH  register-file write data

## Operation
- MDU handshake: transfer when `mdu_valid && mdu_ready`. `mdu_ready = (count != FIFO_DEPTH)`, computed from registered count only; it is not raised by a same-cycle pop.
- Accepted results with `mdu_rd == 0` are consumed but not stored.
- Pipeline write is effective when `reg_write_w && rd_w != 0`.
- Grant, evaluated combinationally each cycle:
  - forced drain (`stall_w = 1`): grant the FIFO head, pop it, and ignore the pipeline request.
  - else, effective pipeline write: grant the pipeline.
  - else, FIFO non-empty: grant the head and pop it.
  - else: `rf_we = 0`.
- `rf_rd` and `rf_wd` come from the granted source. When `rf_we = 0`, both are 0.
- Ordering kill: any effective pipeline write that is granted invalidates every valid FIFO entry with a matching rd, in the same cycle. This preserves program order: the younger pipeline value wins. Killed entries are popped without writing when they reach the head. Popping a killed head is not a grant and does not reset the starve counter.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Starve counter: clears when the head is granted or the FIFO is empty. Otherwise it increments each cycle the head waits, saturating at `STARVE_LIMIT`.

## Timing
- Reset values: FIFO empty, all entries invalid, starve counter 0, `mdu_ready = 1`, `stall_w = 0`, `rf_we = 0`, `rf_rd = 0`, `rf_wd = 0`.
- Reset asserted mid-operation discards all buffered results immediately.
- Minimum MDU latency is 1 cycle: a result pushed in cycle N can be written in cycle N+1 if the pipeline slot is idle.
- Pipeline writes have 0-cycle latency, combinational to the `rf_*` outputs, except in forced-drain cycles. In a forced-drain cycle the pipeline write is performed the next cycle from its held inputs.
- `stall_w` is asserted for exactly one cycle per forced drain. The counter clears on that grant, so the next forced drain is at least `STARVE_LIMIT` cycles later.

## Configuration
- `WB_ARB_STARVE_GUARD_EN` defined:
  - starve counter and forced drain are present.
  - `stall_w` is asserted when the counter equals `STARVE_LIMIT` and the head entry is valid.
- Undefined:
  - no counter is built.
  - `stall_w` is tied to 0.
  - MDU results drain only in cycles with no effective pipeline write; `mdu_ready` back-pressure is the only throttle.

## Structure
- Shared package `wb_arb_pkg`:
  - `rf_addr_t` (5-bit)
  - grant encoding: `GNT_NONE`, `GNT_PIPE`, `GNT_MDU`
  - default depth and limit constants
- Sub-module `wb_result_fifo` holds the entries, each {valid, rd, data}. It provides:
  - push/pop
  - parallel rd-match kill port
  - count, full and empty
- The grant logic and starve counter live in the top module.

## Test plan
- Idle pipeline: push MDU {rd=5, data=0x1234} → next cycle `rf_we=1`, `rf_rd=5`, `rf_wd=0x1234`; FIFO empty after.
- Continuous pipeline writes, two MDU pushes → `mdu_ready` drops to 0 with count=2. A third `mdu_valid` is held, not lost.
- Kill: FIFO holds {rd=7, 0xAAAA}; pipeline writes rd=7 with 0xBBBB → x7 ends as 0xBBBB, and the killed entry is dropped without `rf_we`.
- MDU result with rd=0 → accepted, never written, count unchanged.
- Guard on: pipeline writes every cycle, one MDU entry → `stall_w=1` on the ninth waiting cycle (`STARVE_LIMIT=8`), MDU written, pipeline write follows next cycle. Guard off: `stall_w` stays 0 and the entry waits.
- Assert `rst_n=0` with FIFO full → outputs reach reset values immediately; after release, `mdu_ready=1` and no stale writes occur.
